// File: rtl/jtkiwi_shr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : jtkiwi_shr_arb
//  Purpose  : Shares one synchronous 8 KB BRAM between the main and sub CPUs.
//             Round-robin on ties, one RAM access per chip-select assertion,
//             CPUs held off through active-low wait lines.
//  Revision : 1.0  initial release
// ============================================================================
module jtkiwi_shr_arb #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          sub_en,
    input  logic          main_cs,
    input  logic          main_rnw,
    input  logic [AW-1:0] main_addr,
    input  logic [DW-1:0] main_din,
    output logic [DW-1:0] main_dout,
    output logic          main_wait_n,
    input  logic          sub_cs,
    input  logic          sub_rnw,
    input  logic [AW-1:0] sub_addr,
    input  logic [DW-1:0] sub_din,
    output logic [DW-1:0] sub_dout,
    output logic          sub_wait_n,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_load;

    logic          r_gnt_sub;   // CPU owning the access in flight
    logic          r_last_sub;  // most recent winner, loses the next tie
    logic          r_rd;        // access in flight is a read
    logic          r_done_m;
    logic          r_done_s;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_din;
    logic          r_ram_we;
    logic [DW-1:0] r_main_dout;
    logic [DW-1:0] r_sub_dout;

    logic          w_pend_m;
    logic          w_pend_s;
    logic          w_cand_m;
    logic          w_cand_s;
    logic          w_win_sub;

    // A request is outstanding until its access completes; sub is masked by sub_en
    assign w_pend_m = main_cs & ~r_done_m;
    assign w_pend_s = sub_cs & ~r_done_s & sub_en;

    // Wait lines ignore sub_en so a disabled sub simply stalls
    assign main_wait_n = ~(main_cs & ~r_done_m);
    assign sub_wait_n  = ~(sub_cs & ~r_done_s);

    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign ram_we    = r_ram_we;
    assign main_dout = r_main_dout;
    assign sub_dout  = r_sub_dout;

    // Grant candidates: anyone in IDLE, only the other CPU while finishing in DATA
    always_comb begin
        w_cand_m = 1'b0;
        w_cand_s = 1'b0;
        if (r_state == ST_IDLE) begin
            w_cand_m = w_pend_m;
            w_cand_s = w_pend_s;
        end else if (r_state == ST_DATA) begin
            w_cand_m = w_pend_m & r_gnt_sub;
            w_cand_s = w_pend_s & ~r_gnt_sub;
        end
        w_win_sub = w_cand_s & (~w_cand_m | ~r_last_sub);
    end

    // Next-state logic; w_load marks an edge that starts a new access
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cand_m | w_cand_s) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ACC;
                end
            end
            ST_ACC: w_state_nxt = ST_DATA;
            ST_DATA: begin
                if (w_cand_m | w_cand_s) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ACC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Grant capture, RAM port drive and read-data return
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gnt_sub   <= 1'b0;
            r_last_sub  <= 1'b1;
            r_rd        <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_ram_we    <= 1'b0;
            r_main_dout <= '0;
            r_sub_dout  <= '0;
        end else begin
            r_ram_we <= 1'b0;
            if (r_state == ST_DATA && r_rd) begin
                if (r_gnt_sub) r_sub_dout  <= ram_dout;
                else           r_main_dout <= ram_dout;
            end
            if (w_load) begin
                r_gnt_sub  <= w_win_sub;
                r_last_sub <= w_win_sub;
                r_rd       <= w_win_sub ? sub_rnw  : main_rnw;
                r_ram_we   <= w_win_sub ? ~sub_rnw : ~main_rnw;
                r_ram_addr <= w_win_sub ? sub_addr : main_addr;
                r_ram_din  <= w_win_sub ? sub_din  : main_din;
            end
        end
    end

    // Completion flags: set when the owner's access finishes, cleared whenever cs is low
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_done_m <= 1'b0;
            r_done_s <= 1'b0;
        end else begin
            if (!main_cs)
                r_done_m <= 1'b0;
            else if (r_state == ST_DATA && !r_gnt_sub)
                r_done_m <= 1'b1;
            if (!sub_cs)
                r_done_s <= 1'b0;
            else if (r_state == ST_DATA && r_gnt_sub)
                r_done_s <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtkiwi_shr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtkiwi_shr_arb
//  Purpose  : Directed bench for the shared-RAM arbiter with a BRAM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtkiwi_shr_arb;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sub_en = 1'b0;
    logic        main_cs = 1'b0, main_rnw = 1'b1;
    logic [12:0] main_addr = '0;
    logic [7:0]  main_din = '0;
    logic [7:0]  main_dout;
    logic        main_wait_n;
    logic        sub_cs = 1'b0, sub_rnw = 1'b1;
    logic [12:0] sub_addr = '0;
    logic [7:0]  sub_din = '0;
    logic [7:0]  sub_dout;
    logic        sub_wait_n;
    logic [12:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;

    int checks = 0;
    int failures = 0;

    jtkiwi_shr_arb #(.AW(13), .DW(8)) dut (
        .clk(clk), .rstn(rstn), .sub_en(sub_en),
        .main_cs(main_cs), .main_rnw(main_rnw), .main_addr(main_addr),
        .main_din(main_din), .main_dout(main_dout), .main_wait_n(main_wait_n),
        .sub_cs(sub_cs), .sub_rnw(sub_rnw), .sub_addr(sub_addr),
        .sub_din(sub_din), .sub_dout(sub_dout), .sub_wait_n(sub_wait_n),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM model with a bench-side preload port
    logic [7:0]  mem [0:8191];
    logic        pre_we = 1'b0;
    logic [12:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Write-strobe monitor: counts pulses, logs addresses, flags back-to-back strobes
    int          we_cnt = 0;
    int          we_viol = 0;
    logic        we_prev = 1'b0;
    logic [12:0] we_log [$];
    always @(posedge clk) begin
        if (ram_we) begin
            we_cnt++;
            we_log.push_back(ram_addr);
            if (we_prev) we_viol++;
        end
        we_prev = ram_we;
    end

    // Counts cycles where a held, disabled sub request is wrongly released
    logic watch_sub = 1'b0;
    int   sub_hi = 0;
    always @(negedge clk) if (watch_sub && sub_cs && sub_wait_n) sub_hi++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [12:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Raise the selected chip selects at a falling edge, count wait cycles, then drop them
    task automatic req(input logic m, input logic mr, input logic [12:0] ma, input logic [7:0] md,
                       input logic s, input logic sr, input logic [12:0] sa, input logic [7:0] sd,
                       output int mc, output int sc);
        logic rel;
        if (m) begin main_cs = 1'b1; main_rnw = mr; main_addr = ma; main_din = md; end
        if (s) begin sub_cs = 1'b1; sub_rnw = sr; sub_addr = sa; sub_din = sd; end
        mc = 0; sc = 0; rel = 1'b0;
        for (int i = 0; i < 20 && !rel; i++) begin
            @(negedge clk);
            if (m && !main_wait_n) mc++;
            if (s && !sub_wait_n) sc++;
            rel = (!m || main_wait_n) && (!s || sub_wait_n);
        end
        if (!rel) check("req_release", {31'd0, rel}, 32'd1);
        if (m) main_cs = 1'b0;
        if (s) sub_cs = 1'b0;
        @(negedge clk);
    endtask

    int mc, sc, w0;
    logic [12:0] rnd_ma [3] = '{13'h100, 13'h101, 13'h102};
    logic        rnd_mr [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0]  rnd_md [3] = '{8'h11, 8'h00, 8'h44};
    logic [12:0] rnd_sa [3] = '{13'h200, 13'h201, 13'h200};
    logic        rnd_sr [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0]  rnd_sd [3] = '{8'h22, 8'h33, 8'h00};
    int          rnd_we [3] = '{2, 1, 1};
    logic [12:0] rnd_first [3] = '{13'h100, 13'h201, 13'h102};

    initial begin
        // Reset state and RAM preload
        preload(13'h1A5, 8'h5C);
        preload(13'h300, 8'h00);
        @(negedge clk);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_main_dout", main_dout, 0);
        check("rst_main_wait_n", main_wait_n, 1);
        check("rst_sub_wait_n", sub_wait_n, 1);
        rstn = 1'b1;
        @(negedge clk);

        // Uncontended main read
        w0 = we_cnt;
        req(1, 1, 13'h1A5, 8'h00, 0, 1, 13'h0, 8'h00, mc, sc);
        check("rd_wait_cycles", mc, 2);
        check("rd_main_dout", main_dout, 8'h5C);
        check("rd_no_we", we_cnt - w0, 0);

        // Sub write then main read of the same location
        sub_en = 1'b1;
        w0 = we_cnt; we_log.delete();
        req(0, 1, 13'h0, 8'h00, 1, 0, 13'h0010, 8'h7E, mc, sc);
        check("sw_wait_cycles", sc, 2);
        check("sw_we_count", we_cnt - w0, 1);
        check("sw_we_addr", we_log[0], 13'h0010);
        check("sw_mem", mem[13'h0010], 8'h7E);
        req(1, 1, 13'h0010, 8'h00, 0, 1, 13'h0, 8'h00, mc, sc);
        check("mr_main_dout", main_dout, 8'h7E);
        // Sub read leaves sub as last winner so main takes the next tie
        req(0, 1, 13'h0, 8'h00, 1, 1, 13'h0010, 8'h00, mc, sc);
        check("sr_sub_dout", sub_dout, 8'h7E);

        // Three simultaneous requests
        for (int r = 0; r < 3; r++) begin
            w0 = we_cnt; we_log.delete();
            req(1, rnd_mr[r], rnd_ma[r], rnd_md[r], 1, rnd_sr[r], rnd_sa[r], rnd_sd[r], mc, sc);
            check($sformatf("tie%0d_main_wait", r), mc, 2);
            check($sformatf("tie%0d_sub_wait", r), sc, 4);
            check($sformatf("tie%0d_we_count", r), we_cnt - w0, rnd_we[r]);
            if (we_log.size() > 0) check($sformatf("tie%0d_first_we", r), we_log[0], rnd_first[r]);
            else check($sformatf("tie%0d_we_log", r), we_log.size(), 1);
        end
        check("tie_mem_main", mem[13'h102], 8'h44);
        check("tie_mem_sub", mem[13'h201], 8'h33);
        check("tie_sub_dout", sub_dout, 8'h22);

        // Disabled sub held for 50 cycles while main runs 5 reads
        sub_en = 1'b0;
        sub_cs = 1'b1; sub_rnw = 1'b0; sub_addr = 13'h300; sub_din = 8'h55;
        watch_sub = 1'b1; sub_hi = 0; w0 = we_cnt;
        for (int k = 4; k >= 0; k--)
            req(1, 1, 13'h100 + 13'(k), 8'h00, 0, 1, 13'h0, 8'h00, mc, sc);
        repeat (30) @(negedge clk);
        watch_sub = 1'b0;
        check("dis_sub_waited", sub_hi, 0);
        check("dis_no_we", we_cnt - w0, 0);
        check("dis_mem_untouched", mem[13'h300], 8'h00);
        check("dis_main_dout", main_dout, 8'h11);
        sub_en = 1'b1;
        req(0, 1, 13'h0, 8'h00, 1, 0, 13'h300, 8'h55, mc, sc);
        check("en_sub_wait", sc, 2);
        check("en_mem", mem[13'h300], 8'h55);

        // cs held long after completion gives one access; a new pulse gives another
        w0 = we_cnt;
        main_cs = 1'b1; main_rnw = 1'b0; main_addr = 13'h400; main_din = 8'h66;
        repeat (22) @(negedge clk);
        check("hold_we_count", we_cnt - w0, 1);
        check("hold_wait_n", main_wait_n, 1);
        main_cs = 1'b0;
        @(negedge clk);
        w0 = we_cnt;
        main_cs = 1'b1; main_din = 8'h77;
        repeat (5) @(negedge clk);
        check("pulse2_we_count", we_cnt - w0, 1);
        check("pulse2_mem", mem[13'h400], 8'h77);
        main_cs = 1'b0;
        @(negedge clk);

        // Reset during ACC of a main write
        main_cs = 1'b1; main_rnw = 1'b0; main_addr = 13'h500; main_din = 8'h99;
        @(negedge clk);
        check("acc_we_high", ram_we, 1);
        check("acc_addr", ram_addr, 13'h500);
        rstn = 1'b0;
        #1;
        check("ar_ram_we", ram_we, 0);
        check("ar_ram_addr", ram_addr, 0);
        check("ar_ram_din", ram_din, 0);
        check("ar_main_dout", main_dout, 0);
        check("ar_sub_dout", sub_dout, 0);
        check("ar_main_wait_n", main_wait_n, 0);
        check("ar_sub_wait_n", sub_wait_n, 1);
        main_cs = 1'b0;
        @(negedge clk);
        check("ar_main_wait_idle", main_wait_n, 1);
        rstn = 1'b1;
        @(negedge clk);
        w0 = we_cnt; we_log.delete();
        req(1, 0, 13'h501, 8'hAA, 1, 0, 13'h502, 8'hBB, mc, sc);
        check("post_main_wait", mc, 2);
        check("post_sub_wait", sc, 4);
        if (we_log.size() > 0) check("post_first_we", we_log[0], 13'h501);
        else check("post_we_log", we_log.size(), 2);
        check("post_we_count", we_cnt - w0, 2);

        check("we_single_cycle", we_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a stimulus step never returns
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/jtkiwi_shr_arb.md
Name: jtkiwi_shr_arb

Overview:
- Arbitrates the single-port 8 KB shared RAM between the main CPU and the sub CPU.
- Each CPU requests with a chip select, is held off through an active-low wait line, and receives read data from a per-CPU register.
- Sits between jtkiwi_main/jtkiwi_snd and one synchronous BRAM. The main CPU gates sub access through sub_en, which is driven from mshramen.

Parameters:
AW, 13, shared RAM address width
DW, 8, data width

Ports:
clk  in  1  system clock (24 MHz domain)
rstn  in  1  asynchronous active-low reset
sub_en  in  1  sub CPU allowed to access shared RAM (mshramen)
main_cs  in  1  main CPU request
main_rnw  in  1  main read(1)/write(0)
main_addr  in  AW  main address
main_din  in  DW  main write data
main_dout  out  DW  main read data (registered)
main_wait_n  out  1  low while main request is outstanding
sub_cs  in  1  sub CPU request
sub_rnw  in  1  sub read/write
sub_addr  in  AW  sub address
sub_din  in  DW  sub write data
sub_dout  out  DW  sub read data (registered)
sub_wait_n  out  1  low while sub request is outstanding
ram_addr  out  AW  RAM address (registered)
ram_din  out  DW  RAM write data (registered)
ram_we  out  1  RAM write strobe, one cycle per write
ram_dout  in  DW  RAM read data, valid one cycle after ram_addr is presented

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, ram_addr=0, ram_din=0, ram_we=0.
  - main_dout=0, sub_dout=0, done flags=0.
  - last_grant=SUB, so main wins the first tie.
  - Wait outputs follow their formula (high while cs=0).
- Pending requests:
  - pend_m = main_cs & ~done_m.
  - pend_s = sub_cs & ~done_s & sub_en.
- Wait outputs (combinational):
  - main_wait_n = ~(main_cs & ~done_m).
  - sub_wait_n = ~(sub_cs & ~done_s). A disabled sub stays waited until sub_en rises.
- done_x is set when x's access completes. It is cleared on any edge where x_cs=0. Each cs assertion therefore produces exactly one RAM access.
- Arbitration (at an edge in IDLE or DATA with any pending request):
  - Only one pending: grant it.
  - Both pending: grant the one that is not last_grant.
  - Then last_grant<=winner.
- FSM:
  - IDLE: with a pending request, register addr/din and ram_we<=~rnw of the winner, then ->ACC. Otherwise stay.
  - ACC: ram_we<=0, ->DATA.
  - DATA:
    - Capture ram_dout into the granted CPU's dout on reads. Writes leave dout unchanged.
    - Set done of the granted CPU if its cs is still high.
    - If another request is pending, grant it directly as in IDLE, then ->ACC. Otherwise ->IDLE.
- Latency:
  - Uncontended: cs sampled high at edge t; ram_we/addr valid from t; wait_n rises after edge t+2.
  - Contended loser: address presented at t+2, released after t+4.
  - Back-to-back accesses have no idle bubble.
- The grant is frozen during ACC/DATA; address/data/rnw changes from the CPU are ignored.
- cs dropped mid-access: the RAM access completes (a write is still committed) and dout is still captured on reads. done is not set.
- sub_en falling during a sub access: the access completes. Later sub requests stay pending-masked.
- ram_we is never high for more than one consecutive cycle per grant. It is never asserted in DATA/IDLE except on a new grant edge.
- An async reset mid-access aborts immediately. A write already strobed stays committed; nothing else is guaranteed.

Test Plan:
- Main reads 0x1A5 (RAM preloaded 0x5C), sub idle:
  - main_wait_n low for exactly 2 cycles.
  - main_dout=0x5C.
  - ram_we never asserted.
- Sub writes 0x7E to 0x0010 with sub_en=1, then main reads 0x0010:
  - single ram_we pulse with ram_addr=0x0010, ram_din=0x7E.
  - main_dout=0x7E.
- Main and sub assert cs on the same edge, three times in a row:
  - grants alternate main, sub, main.
  - loser's wait_n stays low 4 cycles.
  - exactly one ram_we per write request.
- sub_en=0, sub_cs held high for 50 cycles while main performs 5 accesses:
  - sub_wait_n stays low and no sub access occurs.
  - after sub_en rises, the sub access completes 2 cycles later.
- cs held high for 20 cycles after completion:
  - exactly one RAM access.
  - a new cs pulse after deassertion triggers a second access.
- rstn pulsed low during ACC of a main write:
  - all outputs return to reset values asynchronously.
  - the next main_cs grants main first.
